uart_tx_pkt_ser: RTL and testbench



---
 rtl/uart_tx_pkt_ser.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_pkt_ser.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_pkt_ser.sv
// rtl/uart_tx_pkt_ser.sv - word-to-byte packet serializer with optional header/checksum framing
// feeding an inferred byte FIFO drained by the UART TX engine.
module uart_tx_pkt_ser #(
  parameter int          WORD_BYTES = 4,
  parameter int          FIFO_DEPTH = 128,
  parameter int          ALEMPTY_TH = 4,
  parameter int          MSB_FIRST  = 0,
  parameter int          HDR_EN     = 1,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5,
  parameter int          CSUM_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*WORD_BYTES-1:0]       i_tx_data,
  input  logic                          i_tx_data_vld,
  output logic                          o_tx_ready,
  output logic                          o_tx_busy,
  output logic                          o_tx_drop,
  input  logic                          i_urttx_rd_en,
  output logic [7:0]                    o_urttx_rd_dat,
  output logic                          o_urttx_empty,
  output logic                          o_urttx_alempty,
  output logic                          o_urttx_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_urttx_usedw
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int UW = AW + 1;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;

  state_t                  state;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [IW-1:0]           idx;
  logic [7:0]              csum;
  logic                    tx_ready;
  logic                    tx_busy;
  logic                    tx_drop;

  logic [7:0]              mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [UW-1:0]           usedw;
  logic [7:0]              rd_dat;

  logic                    full;
  logic                    empty;
  logic                    wr_en;
  logic                    rd_do;
  logic [7:0]              data_byte;
  logic [7:0]              wr_byte;

  assign full  = (usedw == UW'(FIFO_DEPTH));
  assign empty = (usedw == '0);
  assign rd_do = i_urttx_rd_en && !empty;

  always_comb begin
    data_byte = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (idx == IW'(i)) begin
        data_byte = (MSB_FIRST != 0) ? word_q[8*(WORD_BYTES-1-i) +: 8] : word_q[8*i +: 8];
      end
    end
  end

  // A full FIFO freezes the FSM: no write, and state/idx/checksum hold.
  always_comb begin
    wr_en   = (state != S_IDLE) && !full;
    wr_byte = '0;
    case (state)
      S_HDR:   wr_byte = HDR_BYTE;
      S_DATA:  wr_byte = data_byte;
      S_CSUM:  wr_byte = csum;
      default: wr_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      word_q   <= '0;
      idx      <= '0;
      csum     <= '0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_drop  <= 1'b0;
    end else begin
      tx_drop <= i_tx_data_vld && !tx_ready;
      case (state)
        S_IDLE: begin
          if (i_tx_data_vld) begin
            word_q   <= i_tx_data;
            csum     <= '0;
            idx      <= '0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= (HDR_EN != 0) ? S_HDR : S_DATA;
          end
        end
        S_HDR: begin
          if (!full) state <= S_DATA;
        end
        S_DATA: begin
          if (!full) begin
            csum <= csum + data_byte;
            if (idx == IW'(WORD_BYTES-1)) begin
              idx <= '0;
              if (CSUM_EN != 0) begin
                state <= S_CSUM;
              end else begin
                state    <= S_IDLE;
                tx_ready <= 1'b1;
                tx_busy  <= 1'b0;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_CSUM: begin
          if (!full) begin
            state    <= S_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
      rd_dat <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_do) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_dat <= mem[rd_ptr];
      end
      case ({wr_en, rd_do})
        2'b10:   usedw <= usedw + UW'(1);
        2'b01:   usedw <= usedw - UW'(1);
        default: usedw <= usedw;
      endcase
    end
  end

  assign o_tx_ready      = tx_ready;
  assign o_tx_busy       = tx_busy;
  assign o_tx_drop       = tx_drop;
  assign o_urttx_rd_dat  = rd_dat;
  assign o_urttx_empty   = empty;
  assign o_urttx_full    = full;
  assign o_urttx_alempty = (usedw <= UW'(ALEMPTY_TH));
  assign o_urttx_usedw   = usedw;

endmodule

// File: tb/tb_uart_tx_pkt_ser.sv
// tb/tb_uart_tx_pkt_ser.sv - scoreboard bench for uart_tx_pkt_ser across three parameter sets
// (0: defaults, 1: 2-byte MSB-first unframed, 2: depth-8 FIFO).
module tb_uart_tx_pkt_ser;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_w = '0;
  logic [2:0]  vld = '0;
  logic [2:0]  rd_en = '0;
  logic [2:0]  ready, busy, drop, empty, alempty, full;
  logic [2:0][7:0] rd_dat;
  logic [7:0]  usedw_a, usedw_b;
  logic [3:0]  usedw_c;

  logic [7:0]  sb [3][$];
  int          wb_p  [3] = '{4, 2, 4};
  bit          msb_p [3] = '{0, 1, 0};
  bit          hdr_p [3] = '{1, 0, 1};
  bit          cs_p  [3] = '{1, 0, 1};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_pkt_ser u_a (
    .clk(clk), .rst(rst), .i_tx_data(data_w[31:0]), .i_tx_data_vld(vld[0]),
    .o_tx_ready(ready[0]), .o_tx_busy(busy[0]), .o_tx_drop(drop[0]),
    .i_urttx_rd_en(rd_en[0]), .o_urttx_rd_dat(rd_dat[0]), .o_urttx_empty(empty[0]),
    .o_urttx_alempty(alempty[0]), .o_urttx_full(full[0]), .o_urttx_usedw(usedw_a)
  );

  uart_tx_pkt_ser #(.WORD_BYTES(2), .MSB_FIRST(1), .HDR_EN(0), .CSUM_EN(0)) u_b (
    .clk(clk), .rst(rst), .i_tx_data(data_w[15:0]), .i_tx_data_vld(vld[1]),
    .o_tx_ready(ready[1]), .o_tx_busy(busy[1]), .o_tx_drop(drop[1]),
    .i_urttx_rd_en(rd_en[1]), .o_urttx_rd_dat(rd_dat[1]), .o_urttx_empty(empty[1]),
    .o_urttx_alempty(alempty[1]), .o_urttx_full(full[1]), .o_urttx_usedw(usedw_b)
  );

  uart_tx_pkt_ser #(.FIFO_DEPTH(8)) u_c (
    .clk(clk), .rst(rst), .i_tx_data(data_w[31:0]), .i_tx_data_vld(vld[2]),
    .o_tx_ready(ready[2]), .o_tx_busy(busy[2]), .o_tx_drop(drop[2]),
    .i_urttx_rd_en(rd_en[2]), .o_urttx_rd_dat(rd_dat[2]), .o_urttx_empty(empty[2]),
    .o_urttx_alempty(alempty[2]), .o_urttx_full(full[2]), .o_urttx_usedw(usedw_c)
  );

  function automatic logic [7:0] uw(input int k);
    case (k)
      0:       return usedw_a;
      1:       return usedw_b;
      default: return {4'b0, usedw_c};
    endcase
  endfunction

  function automatic bq_t mk_pkt(input int k, input logic [63:0] w);
    bq_t p;
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    if (hdr_p[k]) p.push_back(8'hA5);
    for (int i = 0; i < wb_p[k]; i++) begin
      b = msb_p[k] ? w[8*(wb_p[k]-1-i) +: 8] : w[8*i +: 8];
      p.push_back(b);
      s = s + b;
    end
    if (cs_p[k]) p.push_back(s);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Presents a word for one cycle; returns at the negedge of the cycle after acceptance.
  task automatic send(input int k, input logic [63:0] w);
    bq_t p;
    chk("ready_before_send", {31'b0, ready[k]}, 32'd1);
    data_w = w;
    vld[k] = 1'b1;
    p = mk_pkt(k, w);
    foreach (p[i]) sb[k].push_back(p[i]);
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int c;
    c = 0;
    while (!ready[k] && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", {31'b0, ready[k]}, 32'd1);
  endtask

  task automatic rd_bytes(input int k, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      rd_en[k] = 1'b1;
      @(negedge clk);
      e = sb[k].pop_front();
      chk("rd_dat", {24'b0, rd_dat[k]}, {24'b0, e});
    end
    rd_en[k] = 1'b0;
  endtask

  initial begin
    int cnt;
    int drops;
    bit acc2;
    int exp_used;
    logic [7:0] e;
    logic [7:0] last_b;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'b0, ready[k]}, 32'd1);
      chk("rst_busy", {31'b0, busy[k]}, 32'd0);
      chk("rst_drop", {31'b0, drop[k]}, 32'd0);
      chk("rst_rd_dat", {24'b0, rd_dat[k]}, 32'd0);
      chk("rst_empty", {31'b0, empty[k]}, 32'd1);
      chk("rst_alempty", {31'b0, alempty[k]}, 32'd1);
      chk("rst_full", {31'b0, full[k]}, 32'd0);
      chk("rst_usedw", {24'b0, uw(k)}, 32'd0);
    end

    // Basic framed packet and timing
    send(0, 64'h44332211);
    chk("n1_ready", {31'b0, ready[0]}, 32'd0);
    chk("n1_busy", {31'b0, busy[0]}, 32'd1);
    chk("n1_empty", {31'b0, empty[0]}, 32'd1);
    cnt = 0;
    while (busy[0] && cnt < 20) begin
      cnt++;
      @(negedge clk);
      if (cnt == 1) chk("n2_empty", {31'b0, empty[0]}, 32'd0);
    end
    chk("busy_cycles", cnt, 32'd6);
    chk("n7_ready", {31'b0, ready[0]}, 32'd1);
    chk("pkt_usedw", {24'b0, usedw_a}, 32'd6);
    rd_bytes(0, 6);
    chk("drain_empty", {31'b0, empty[0]}, 32'd1);

    // Checksum wrap: 4 x FF -> FC
    send(0, 64'hFFFFFFFF);
    wait_idle(0);
    rd_bytes(0, 6);

    // MSB-first, unframed 2-byte word
    send(1, 64'hBEEF);
    wait_idle(1);
    chk("b_usedw", {24'b0, usedw_b}, 32'd2);
    rd_bytes(1, 2);
    chk("b_empty", {31'b0, empty[1]}, 32'd1);

    // vld held high through the packet: drops, then back-to-back accept
    data_w = 64'h44332211;
    vld[0] = 1'b1;
    begin
      bq_t p;
      p = mk_pkt(0, 64'h44332211);
      foreach (p[i]) sb[0].push_back(p[i]);
    end
    @(negedge clk);
    data_w = 64'h12345678;
    drops = 0;
    acc2 = 0;
    for (int c = 0; c < 12; c++) begin
      if (drop[0]) drops++;
      if (ready[0] && vld[0]) begin
        bq_t p;
        p = mk_pkt(0, 64'h12345678);
        foreach (p[i]) sb[0].push_back(p[i]);
        acc2 = 1;
      end
      @(negedge clk);
      if (acc2 && vld[0]) begin
        vld[0] = 1'b0;
        chk("b2b_ready_low", {31'b0, ready[0]}, 32'd0);
      end
    end
    chk("drop_count", drops, 32'd6);
    chk("b2b_accepted", {31'b0, acc2}, 32'd1);
    wait_idle(0);
    chk("b2b_usedw", {24'b0, usedw_a}, 32'd12);
    rd_bytes(0, 12);

    // Depth-8 FIFO fills and stalls
    send(2, 64'h44332211);
    wait_idle(2);
    send(2, 64'h0A0B0C0D);
    repeat (10) @(negedge clk);
    chk("stall_usedw", {24'b0, uw(2)}, 32'd8);
    chk("stall_full", {31'b0, full[2]}, 32'd1);
    chk("stall_busy", {31'b0, busy[2]}, 32'd1);
    rd_bytes(2, 4);
    wait_idle(2);
    chk("resume_usedw", {24'b0, uw(2)}, 32'd8);
    rd_bytes(2, 8);
    chk("c_empty", {31'b0, empty[2]}, 32'd1);

    // Simultaneous read/write at usedw=7, then alempty boundary and empty read
    send(2, 64'h01020304);
    wait_idle(2);
    chk("c_usedw6", {24'b0, uw(2)}, 32'd6);
    send(2, 64'h55667788);
    @(negedge clk);
    chk("c_usedw7", {24'b0, uw(2)}, 32'd7);
    for (int i = 0; i < 5; i++) begin
      rd_en[2] = 1'b1;
      @(negedge clk);
      e = sb[2].pop_front();
      chk("rw_rd_dat", {24'b0, rd_dat[2]}, {24'b0, e});
      chk("rw_usedw", {24'b0, uw(2)}, 32'd7);
      chk("rw_full", {31'b0, full[2]}, 32'd0);
    end
    chk("rw_done_busy", {31'b0, busy[2]}, 32'd0);
    exp_used = 7;
    chk("al_7", {31'b0, alempty[2]}, 32'd0);
    last_b = 8'h00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp_used--;
      e = sb[2].pop_front();
      last_b = e;
      chk("dr_rd_dat", {24'b0, rd_dat[2]}, {24'b0, e});
      chk("dr_usedw", {24'b0, uw(2)}, exp_used);
      chk("dr_alempty", {31'b0, alempty[2]}, (exp_used <= 4) ? 32'd1 : 32'd0);
    end
    repeat (2) @(negedge clk);
    rd_en[2] = 1'b0;
    chk("empty_rd_hold", {24'b0, rd_dat[2]}, {24'b0, last_b});
    chk("empty_rd_usedw", {24'b0, uw(2)}, 32'd0);
    chk("empty_rd_empty", {31'b0, empty[2]}, 32'd1);

    // Reset mid-packet
    send(0, 64'hCAFEF00D);
    repeat (3) @(negedge clk);
    chk("pre_rst_usedw", {24'b0, usedw_a}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb[0].delete();
    chk("post_rst_ready", {31'b0, ready[0]}, 32'd1);
    chk("post_rst_busy", {31'b0, busy[0]}, 32'd0);
    chk("post_rst_empty", {31'b0, empty[0]}, 32'd1);
    chk("post_rst_usedw", {24'b0, usedw_a}, 32'd0);
    send(0, 64'h9876ABCD);
    wait_idle(0);
    chk("after_rst_usedw", {24'b0, usedw_a}, 32'd6);
    rd_bytes(0, 6);
    chk("after_rst_empty", {31'b0, empty[0]}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
